// File: rtl/mem_stream_reader_pkg.sv
// Shared constants and FSM encoding for the memory stream reader.
package mem_stream_reader_pkg;

    localparam logic [1:0]  ACC_WORD       = 2'b00;
    localparam logic [1:0]  ACC_HALF       = 2'b01;
    localparam logic [1:0]  ACC_BYTE       = 2'b10;
    localparam logic [31:0] MEM_START_ADDR = 32'h8002_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_t;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stream_reader_rd_skid_fifo.sv
// Small return buffer for read data plus its address; supports push and pop
// in the same cycle, including when full.
module rd_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] count,
    output logic             empty
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = store[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Walks a word range of mainMem and streams each word (with its byte address)
// out on a valid/ready interface. Read-only towards memory.
//
//   state  | meaning
//   IDLE   | waiting for start
//   ISSUE  | issuing reads while return-buffer credits allow
//   DRAIN  | all reads issued; waiting for returns and buffer to empty
//   FINISH | one-cycle done pulse
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wren,
    output logic              mem_enable,
    output logic [1:0]        mem_acc_size,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err_align
);

    localparam int                OCC_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W:0]    DEPTH_L    = (OCC_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    rd_state_t          state;
    rd_state_t          state_n;
    logic [ADDR_W-1:0]  cur_addr;
    logic [ADDR_W-1:0]  ret_addr;
    logic [CNT_W-1:0]   remaining;
    logic               ret_valid;
    logic               misaligned;
    logic               issue;
    logic               accept;
    logic               pop;
    logic [OCC_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [OCC_W:0]     credit_used;

    // Bits [1:0] here are bits [30:31] in mainMem's MSB-first numbering.
    assign misaligned = !is_word_aligned(base_addr[1:0]);

    // The same-cycle pop frees a slot, which keeps one word per cycle flowing
    // with a two-entry buffer and single-cycle read latency.
    assign credit_used = {1'b0, fifo_count} + (OCC_W + 1)'(ret_valid) - (OCC_W + 1)'(pop);
    assign issue       = (state == ST_ISSUE) && (remaining != '0) && (credit_used < DEPTH_L);
    assign accept      = issue && !mem_busy;

    assign out_valid    = !fifo_empty;
    assign pop          = out_valid && out_ready;
    assign mem_enable   = issue;
    assign mem_addr     = cur_addr;
    assign mem_data_in  = '0;
    assign mem_wren     = 1'b0;
    assign mem_acc_size = ACC_WORD;
    assign busy         = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign done         = (state == ST_FINISH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (start && !misaligned) begin
                    state_n = (word_count == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (accept && remaining == CNT_W'(1)) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!ret_valid && fifo_count == OCC_W'(pop)) begin
                    state_n = ST_FINISH;
                end
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            err_align <= 1'b0;
            ret_valid <= 1'b0;
            ret_addr  <= '0;
        end else begin
            ret_valid <= accept;
            if (accept) begin
                ret_addr  <= cur_addr;
                cur_addr  <= cur_addr + WORD_BYTES;
                remaining <= remaining - CNT_W'(1);
            end else if (state == ST_IDLE && start) begin
                err_align <= misaligned;
                if (!misaligned) begin
                    cur_addr  <= base_addr;
                    remaining <= word_count;
                end
            end
        end
    end

    rd_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W),
        .OCC_W (OCC_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (ret_valid),
        .push_data ({ret_addr, mem_data_out}),
        .pop       (pop),
        .head_data ({out_addr, out_data}),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule
